// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out bundle between the raster source, the 3x3 window
// generator and the weighted_average filter downstream.
interface window_gen_3x3_if #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int IMG_WIDTH     = 16,
    parameter int IMG_HEIGHT    = 16
);
    logic                                  t;
    logic                                  in_valid;
    logic [ELEMENT_WIDTH-1:0]              in_data;
    logic                                  in_ready;
    logic [2:0][2:0][ELEMENT_WIDTH-1:0]    win_data;
    logic                                  win_valid;
    logic [$clog2(IMG_HEIGHT)-1:0]         win_row;
    logic [$clog2(IMG_WIDTH)-1:0]          win_col;
    logic                                  frame_done;

    modport master (
        output t, in_valid, in_data,
        input  in_ready, win_data, win_valid, win_row, win_col, frame_done
    );

    modport slave (
        input  t, in_valid, in_data,
        output in_ready, win_data, win_valid, win_row, win_col, frame_done
    );
endinterface

// File: rtl/window_gen_3x3.sv
// Raster pixel stream to 3x3 sliding window: two line buffers feed the
// upper window rows, the live pixel feeds the bottom row.

module window_gen_3x3_row #(
    parameter int EW = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [EW-1:0]         din,
    output logic [2:0][EW-1:0]    taps
);
    always_ff @(posedge clk) begin
        if (rst) begin
            taps <= '0;
        end else if (en) begin
            taps[0] <= taps[1];
            taps[1] <= taps[2];
            taps[2] <= din;
        end
    end
endmodule

module window_gen_3x3 #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int IMG_WIDTH     = 16,
    parameter int IMG_HEIGHT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    window_gen_3x3_if.slave   bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

    state_t                             state, state_nxt;
    logic [RW-1:0]                      row;
    logic [CW-1:0]                      col;
    logic                               accept, last_px, interior;
    logic [ELEMENT_WIDTH-1:0]           lb0 [IMG_WIDTH];
    logic [ELEMENT_WIDTH-1:0]           lb1 [IMG_WIDTH];
    logic [2:0][ELEMENT_WIDTH-1:0]      new_col;
    logic [2:0][2:0][ELEMENT_WIDTH-1:0] win;
    logic                               win_vld;
    logic [RW-1:0]                      win_row_q;
    logic [CW-1:0]                      win_col_q;

    assign accept   = bus.in_valid && (state == S_ACTIVE);
    assign last_px  = (row == ROW_LAST) && (col == COL_LAST);
    assign interior = (row >= RW'(2)) && (col >= CW'(2));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (bus.t) state_nxt = S_ACTIVE;
            S_ACTIVE: if (accept && last_px) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line RAM is never cleared; stale contents are harmless because a window
    // is only flagged once two full rows of the current frame are stored.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col] <= lb1[col];
            lb1[col] <= bus.in_data;
        end
    end

    assign new_col = {bus.in_data, lb1[col], lb0[col]};

    for (genvar g = 0; g < 3; g++) begin : g_row
        window_gen_3x3_row #(.EW(ELEMENT_WIDTH)) u_row (
            .clk  (clk),
            .rst  (rst),
            .en   (accept),
            .din  (new_col[g]),
            .taps (win[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_vld   <= 1'b0;
            win_row_q <= '0;
            win_col_q <= '0;
        end else begin
            win_vld <= accept && interior;
            if (accept && interior) begin
                win_row_q <= row - RW'(1);
                win_col_q <= col - CW'(1);
            end
        end
    end

    assign bus.in_ready   = (state == S_ACTIVE);
    assign bus.frame_done = (state == S_DONE);
    assign bus.win_data   = win;
    assign bus.win_valid  = win_vld;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3: a 4x4 and a 16x16 instance checked every cycle
// against a frame-image model, plus literal checks of known windows.
module tb_window_gen_3x3;
    localparam int EW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, rst16;

    window_gen_3x3_if #(.ELEMENT_WIDTH(EW), .IMG_WIDTH(4),  .IMG_HEIGHT(4))  b4 ();
    window_gen_3x3_if #(.ELEMENT_WIDTH(EW), .IMG_WIDTH(16), .IMG_HEIGHT(16)) b16 ();

    window_gen_3x3 #(.ELEMENT_WIDTH(EW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u4 (
        .clk(clk), .rst(rst4), .bus(b4.slave));
    window_gen_3x3 #(.ELEMENT_WIDTH(EW), .IMG_WIDTH(16), .IMG_HEIGHT(16)) u16 (
        .clk(clk), .rst(rst16), .bus(b16.slave));

    typedef logic [2:0][2:0][EW-1:0] win_t;

    int vectors = 0, miscompares = 0;

    // model: 0 idle, 1 active, 2 done
    int      ms [2];
    int      mr [2], mc [2];
    logic [EW-1:0] img [2][16][16];
    bit      ev [2], ek [2];
    win_t    ew [2];
    int      erow [2], ecol [2];
    int      wcnt [2];
    win_t    first_win [2], last_win [2];
    int      first_row [2], first_col [2];

    task automatic chk(input string nm, input int k, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic step(input int k, input int W, input int H, input logic rst_i,
                        input logic t_i, input logic iv, input logic [EW-1:0] d,
                        input logic rdy, input logic wv, input win_t wd,
                        input int wrow, input int wcol, input logic fd);
        chk("in_ready", k, EW'(rdy), EW'(ms[k] == 1));
        chk("frame_done", k, EW'(fd), EW'(ms[k] == 2));
        chk("win_valid", k, EW'(wv), EW'(ev[k]));
        if (ev[k]) begin
            chk("win_row", k, wrow, erow[k]);
            chk("win_col", k, wcol, ecol[k]);
        end
        if (ek[k])
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    chk($sformatf("win_data[%0d][%0d]", i, j), k, wd[i][j], ew[k][i][j]);
        if (wv === 1'b1) begin
            if (wcnt[k] == 0) begin
                first_win[k] = wd;
                first_row[k] = wrow;
                first_col[k] = wcol;
            end
            last_win[k] = wd;
            wcnt[k]++;
        end
        // advance the model to what the next edge must produce
        ev[k] = 1'b0;
        if (rst_i) begin
            ms[k] = 0; mr[k] = 0; mc[k] = 0;
            ek[k] = 1'b1; ew[k] = '0;
        end else if (ms[k] == 0) begin
            if (t_i) ms[k] = 1;
        end else if (ms[k] == 2) begin
            ms[k] = 0;
        end else if (iv) begin
            img[k][mr[k]][mc[k]] = d;
            if (mr[k] >= 2 && mc[k] >= 2) begin
                ev[k] = 1'b1; ek[k] = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ew[k][i][j] = img[k][mr[k]-2+i][mc[k]-2+j];
                erow[k] = mr[k] - 1;
                ecol[k] = mc[k] - 1;
            end else begin
                ek[k] = 1'b0;
            end
            if (mc[k] == W - 1) begin
                mc[k] = 0;
                if (mr[k] == H - 1) begin mr[k] = 0; ms[k] = 2; end
                else mr[k]++;
            end else begin
                mc[k]++;
            end
        end
    endtask

    always @(negedge clk) begin
        step(0, 4, 4, rst4, b4.t, b4.in_valid, b4.in_data, b4.in_ready, b4.win_valid,
             b4.win_data, int'(b4.win_row), int'(b4.win_col), b4.frame_done);
        step(1, 16, 16, rst16, b16.t, b16.in_valid, b16.in_data, b16.in_ready, b16.win_valid,
             b16.win_data, int'(b16.win_row), int'(b16.win_col), b16.frame_done);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int k, input logic t_i, input logic v, input logic [EW-1:0] d);
        if (k == 0) begin b4.t = t_i;  b4.in_valid = v;  b4.in_data = d;  end
        else        begin b16.t = t_i; b16.in_valid = v; b16.in_data = d; end
        tick();
    endtask

    // mode: 0 continuous, 1 pattern 1,0,0, 2 random bubbles and random pixels
    task automatic frame(input int k, input int W, input int H, input int base,
                         input int mode, input bit tmid, input int npix);
        int idx = 0;
        put(k, 1'b1, 1'b0, '0);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (idx < npix) begin
                    logic [EW-1:0] d;
                    d = (mode == 2) ? $urandom : EW'(base + r * 16 + c);
                    put(k, tmid && (idx == 5 || idx == 10), 1'b1, d);
                    if (mode == 1) begin
                        put(k, 1'b0, 1'b0, '0);
                        put(k, 1'b0, 1'b0, '0);
                    end else if (mode == 2 && $urandom_range(0, 3) == 0) begin
                        put(k, 1'b0, 1'b0, '0);
                    end
                end
                idx++;
            end
        put(k, 1'b0, 1'b0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            put(0, 1'b0, 1'b0, '0);
        end
    endtask

    task automatic lit4(input int base, input string tag);
        chk({tag, "_count"}, 0, wcnt[0], 4);
        chk({tag, "_first00"}, 0, first_win[0][0][0], EW'(base + 'h00));
        chk({tag, "_first11"}, 0, first_win[0][1][1], EW'(base + 'h11));
        chk({tag, "_first22"}, 0, first_win[0][2][2], EW'(base + 'h22));
        chk({tag, "_first_row"}, 0, first_row[0], 1);
        chk({tag, "_first_col"}, 0, first_col[0], 1);
        chk({tag, "_last00"}, 0, last_win[0][0][0], EW'(base + 'h11));
        chk({tag, "_last22"}, 0, last_win[0][2][2], EW'(base + 'h33));
        chk({tag, "_ready_after"}, 0, EW'(b4.in_ready), '0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            ms[k] = 0; mr[k] = 0; mc[k] = 0; ev[k] = 0; ek[k] = 0; wcnt[k] = 0;
        end
        rst4 = 1'b1; rst16 = 1'b1;
        b4.t = 0;  b4.in_valid = 0;  b4.in_data = '0;
        b16.t = 0; b16.in_valid = 0; b16.in_data = '0;
        repeat (3) tick();
        rst4 = 1'b0; rst16 = 1'b0;
        tick();
        chk("reset_win_row", 0, EW'(b4.win_row), '0);
        chk("reset_ready", 1, EW'(b16.in_ready), '0);

        // continuous 4x4 frame
        wcnt[0] = 0;
        frame(0, 4, 4, 0, 0, 1'b0, 16);
        idle(3);
        lit4(0, "cont");

        // same frame with 1,0,0 valid pattern
        wcnt[0] = 0;
        frame(0, 4, 4, 0, 1, 1'b0, 16);
        idle(3);
        lit4(0, "bubble");

        // in_valid before t is ignored; t re-pulsed mid-frame is ignored
        wcnt[0] = 0;
        put(0, 1'b0, 1'b1, 32'hDEAD);
        put(0, 1'b0, 1'b1, 32'hBEEF);
        put(0, 1'b0, 1'b1, 32'hCAFE);
        frame(0, 4, 4, 0, 0, 1'b1, 16);
        idle(3);
        lit4(0, "tign");

        // reset after 9 accepted pixels, then a clean frame
        frame(0, 4, 4, 'h40, 0, 1'b0, 9);
        rst4 = 1'b1;
        idle(1);
        rst4 = 1'b0;
        idle(1);
        wcnt[0] = 0;
        frame(0, 4, 4, 'h80, 0, 1'b0, 16);
        idle(3);
        lit4('h80, "rst");

        // 16x16 random pixels with random bubbles
        wcnt[1] = 0;
        frame(1, 16, 16, 0, 2, 1'b0, 256);
        repeat (3) put(1, 1'b0, 1'b0, '0);
        chk("rand_count", 1, wcnt[1], 196);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
